// File: rtl/prm_edge_pkg.sv
// prm_edge_pkg: shared FSM state type and default sizes for the edge mask engine
package prm_edge_pkg;
  localparam int CELL_W_DEF = 15;
  localparam int NUM_EDGES_DEF = 32;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
endpackage

// File: rtl/prm_edge_lut.sv
// prm_edge_lut: 1R1W synchronous voxel-to-edge RAM, 1-cycle read, write-first
module prm_edge_lut
  import prm_edge_pkg::*;
#(
  parameter int AW = CELL_W_DEF,
  parameter int DW = NUM_EDGES_DEF
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;
  assign o_rdata = r_rdata;
  // write port plus registered read that forwards same-address write data
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= (i_we && i_waddr == i_raddr) ? i_wdata : r_mem[i_raddr];
  end
endmodule

// File: rtl/prm_edge_mask_engine.sv
// prm_edge_mask_engine: streams obstacle voxels through a LUT and OR-accumulates blocked edges
module prm_edge_mask_engine
  import prm_edge_pkg::*;
#(
  parameter int CELL_W    = CELL_W_DEF,
  parameter int NUM_EDGES = NUM_EDGES_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [CELL_W-1:0]    cfg_addr,
  input  logic [NUM_EDGES-1:0] cfg_data,
  output logic                 cfg_err,
  input  logic                 vox_valid,
  output logic                 vox_ready,
  input  logic [CELL_W-1:0]    vox_id,
  input  logic                 vox_last,
  input  logic                 sticky,
  output logic                 mask_valid,
  input  logic                 mask_ready,
  output logic [NUM_EDGES-1:0] edge_mask,
  output logic [CNT_W-1:0]     vox_count,
  output logic                 busy
);
  state_t r_state, w_next;
  logic r_rd_vld, r_cfg_err;
  logic [NUM_EDGES-1:0] r_acc, w_lut;
  logic [CNT_W-1:0] r_cnt;
  logic w_accept, w_start;
  assign w_accept = vox_valid && r_state == SCAN;
  assign w_start = vox_valid && r_state == IDLE;
  assign vox_ready = r_state == SCAN;
  assign mask_valid = r_state == DONE;
  assign busy = r_state != IDLE;
  assign cfg_err = r_cfg_err;
  assign edge_mask = r_acc;
  assign vox_count = r_cnt;
  prm_edge_lut #(.AW(CELL_W), .DW(NUM_EDGES)) u_lut (
    .clk     (clk),
    .i_we    (cfg_we && r_state == IDLE),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (vox_id),
    .o_rdata (w_lut)
  );
  // frame sequencing: wait, scan beats, let last read land, hold result
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = vox_valid ? SCAN : IDLE;
      SCAN:  w_next = (w_accept && vox_last) ? DRAIN : SCAN;
      DRAIN: w_next = DONE;
      DONE:  w_next = mask_ready ? IDLE : DONE;
    endcase
  end
  // state, read-valid pipeline flag and rejected-write pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rd_vld <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rd_vld <= w_accept;
      r_cfg_err <= cfg_we && r_state != IDLE;
    end
  end
  // accumulate LUT words one cycle after accept; saturating beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_start && !sticky) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      if (r_rd_vld) r_acc <= r_acc | w_lut;
      if (w_accept && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// tb_prm_edge_mask_engine: directed frame table plus hand-written corner sequences
module tb_prm_edge_mask_engine;
  logic clk = 0, rst_n = 0;
  logic cfg_we = 0, vox_valid = 0, vox_last = 0, sticky = 0, mask_ready = 0;
  logic [14:0] cfg_addr = 0, vox_id = 0;
  logic [31:0] cfg_data = 0;
  logic cfg_err, vox_ready, mask_valid, busy;
  logic [31:0] edge_mask;
  logic [1:0] vox_count;
  int pass = 0, total = 0;
  typedef struct {
    logic sticky;
    int n;
    logic [14:0] ids[5];
    logic gaps;
    logic [31:0] m;
    logic [1:0] c;
  } vec_t;
  vec_t vt[8];
  always #5 clk = ~clk;
  prm_edge_mask_engine #(.CELL_W(15), .NUM_EDGES(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .vox_valid(vox_valid), .vox_ready(vox_ready), .vox_id(vox_id),
    .vox_last(vox_last), .sticky(sticky), .mask_valid(mask_valid), .mask_ready(mask_ready),
    .edge_mask(edge_mask), .vox_count(vox_count), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", nm, a, e);
    else pass++;
  endtask
  task automatic cfg_write(input logic [14:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask
  task automatic beat(input logic [14:0] id, input logic l);
    int k = 0;
    vox_valid = 1; vox_id = id; vox_last = l;
    while (!vox_ready && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) chk("beat_timeout", 1, 0);
    tick();
    vox_valid = 0; vox_last = 0;
  endtask
  task automatic finish_frame(input string nm, input logic [31:0] m, input logic [1:0] c);
    chk({nm, "_lat1"}, mask_valid, 0);
    tick();
    chk({nm, "_lat2"}, mask_valid, 1);
    chk({nm, "_mask"}, edge_mask, m);
    chk({nm, "_cnt"}, vox_count, c);
    mask_ready = 1;
    tick();
    mask_ready = 0;
    chk({nm, "_idle"}, busy, 0);
  endtask
  task automatic set_vec(input int i, input logic st, input int n, input logic [14:0] a0, a1, a2, a3, a4,
                         input logic g, input logic [31:0] m, input logic [1:0] c);
    vt[i].sticky = st; vt[i].n = n; vt[i].gaps = g; vt[i].m = m; vt[i].c = c;
    vt[i].ids[0] = a0; vt[i].ids[1] = a1; vt[i].ids[2] = a2; vt[i].ids[3] = a3; vt[i].ids[4] = a4;
  endtask
  initial begin
    set_vec(0, 0, 2, 15'h0005, 15'h7FFF, 0, 0, 0, 0, 32'h8000_0003, 2);
    set_vec(1, 0, 1, 15'h0010, 0, 0, 0, 0, 0, 32'h1, 1);
    set_vec(2, 0, 1, 15'h0011, 0, 0, 0, 0, 0, 32'h2, 1);
    set_vec(3, 0, 1, 15'h0010, 0, 0, 0, 0, 0, 32'h1, 1);
    set_vec(4, 1, 1, 15'h0011, 0, 0, 0, 0, 0, 32'h3, 2);
    set_vec(5, 0, 2, 15'h0005, 15'h0005, 0, 0, 0, 0, 32'h3, 2);
    set_vec(6, 0, 5, 15'h0020, 15'h0021, 15'h0022, 15'h0023, 15'h0024, 1, 32'h1101_1100, 3);
    set_vec(7, 1, 1, 15'h0012, 0, 0, 0, 0, 0, 32'h1101_1100, 3);
    tick();
    tick();
    chk("reset", {mask_valid, vox_ready, busy, cfg_err, vox_count, edge_mask}, 0);
    rst_n = 1;
    cfg_write(15'h0005, 32'h0000_0003);
    cfg_write(15'h7FFF, 32'h8000_0000);
    cfg_write(15'h0010, 32'h0000_0001);
    cfg_write(15'h0011, 32'h0000_0002);
    cfg_write(15'h0012, 32'h0000_0000);
    cfg_write(15'h0020, 32'h0000_0100);
    cfg_write(15'h0021, 32'h0000_1000);
    cfg_write(15'h0022, 32'h0001_0000);
    cfg_write(15'h0023, 32'h0100_0000);
    cfg_write(15'h0024, 32'h1000_0000);
    tick();
    chk("cfg_idle_noerr", cfg_err, 0);
    for (int i = 0; i < 8; i++) begin
      sticky = vt[i].sticky;
      for (int j = 0; j < vt[i].n; j++) begin
        if (vt[i].gaps) repeat ($urandom_range(0, 2)) tick();
        beat(vt[i].ids[j], j == vt[i].n - 1);
      end
      finish_frame($sformatf("vec%0d", i), vt[i].m, vt[i].c);
    end
    sticky = 0;
    beat(15'h0012, 1);
    tick();
    vox_valid = 1; vox_id = 15'h0010; vox_last = 1;
    for (int i = 0; i < 10; i++) begin
      chk("hold", {mask_valid, vox_ready, edge_mask}, {2'b10, 32'h0});
      tick();
    end
    mask_ready = 1;
    tick();
    mask_ready = 0;
    chk("done_exit_only", {busy, vox_ready}, 0);
    beat(15'h0010, 1);
    finish_frame("after_hold", 32'h1, 1);
    beat(15'h0010, 0);
    cfg_we = 1; cfg_addr = 15'h0010; cfg_data = 32'hFFFF_FFFF;
    tick();
    cfg_we = 0;
    chk("cfg_err_pulse", cfg_err, 1);
    tick();
    chk("cfg_err_clear", cfg_err, 0);
    beat(15'h0011, 1);
    finish_frame("cfg_scan", 32'h3, 2);
    beat(15'h0010, 1);
    finish_frame("cfg_old", 32'h1, 1);
    cfg_we = 1; cfg_addr = 15'h0030; cfg_data = 32'h0000_00A5;
    vox_valid = 1; vox_id = 15'h0030; vox_last = 1;
    tick();
    cfg_we = 0;
    beat(15'h0030, 1);
    chk("wf_noerr", cfg_err, 0);
    finish_frame("write_first", 32'hA5, 1);
    beat(15'h0020, 0);
    beat(15'h0021, 0);
    beat(15'h0022, 0);
    rst_n = 0;
    tick();
    chk("mid_reset", {mask_valid, vox_ready, busy, cfg_err, vox_count, edge_mask}, 0);
    rst_n = 1;
    sticky = 1;
    beat(15'h0023, 1);
    finish_frame("post_reset", 32'h0100_0000, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/prm_edge_mask_engine.md
Name: prm_edge_mask_engine

Overview:
- Programmable, multi-edge successor to the per-edge hardwired obstacle-check truth tables.
- Holds an occupancy-to-edge lookup RAM (depth 2^CELL_W, width NUM_EDGES) loaded over a config port.
- Consumes a frame of obstacle voxel IDs over a valid/ready stream and OR-accumulates the blocked-edge vector.
- Presents the final NUM_EDGES-bit edge_mask to the PRM graph-update logic with a valid/ready handshake.

Parameters:
- CELL_W, 15, voxel ID width (matches the 15-input check tables); LUT depth = 2^CELL_W.
- NUM_EDGES, 32, edges checked in parallel; width of the LUT word and of edge_mask.
- CNT_W, 16, width of the per-frame voxel counter (saturating).

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  LUT write strobe
- cfg_addr  in  CELL_W  LUT address (voxel ID)
- cfg_data  in  NUM_EDGES  edges blocked by that voxel (1 = blocked)
- cfg_err  out  1  one-cycle pulse: write rejected (not IDLE)
- vox_valid  in  1  voxel ID valid
- vox_ready  out  1  engine accepts voxel
- vox_id  in  CELL_W  obstacle voxel ID
- vox_last  in  1  last voxel of frame
- sticky  in  1  sampled at frame start; 1 = do not clear accumulator between frames
- mask_valid  out  1  edge_mask result valid
- mask_ready  in  1  consumer accepts result
- edge_mask  out  NUM_EDGES  accumulated blocked-edge vector
- vox_count  out  CNT_W  voxels in the frame, saturating at all-ones
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; vox_ready=0, mask_valid=0, edge_mask=0, vox_count=0, cfg_err=0, busy=0; pipeline valid flag cleared. LUT contents are not reset.
- FSM states and transitions:
  - IDLE → SCAN: on vox_valid=1. Voxels are accepted only in SCAN, so vox_ready=0 in IDLE and the first beat is not consumed.
  - On the IDLE→SCAN transition: sample sticky; if sticky=0, clear the accumulator and vox_count.
  - SCAN → DRAIN: vox_ready=1. A beat transfers on vox_valid&vox_ready. On a transfer with vox_last=1, go to DRAIN.
  - DRAIN: vox_ready=0. Lasts 1 cycle and lets the final LUT read land in the accumulator. Then go to DONE.
  - DONE → IDLE: mask_valid=1; edge_mask and vox_count held stable. Leave on mask_valid&mask_ready.
- Pipeline:
  - Accept cycle t: LUT read issued with vox_id.
  - Cycle t+1: accumulator |= LUT word.
  - Sustained throughput: 1 voxel/clk.
  - Latency from last-beat accept to mask_valid: 2 cycles.
- vox_count increments on each accepted beat and saturates at 2^CNT_W-1; no wrap.
- A duplicate voxel ID is harmless (idempotent OR).
- Config writes:
  - Accepted only in IDLE; 1-cycle write.
  - In any other state the write is dropped and cfg_err pulses on the following cycle.
  - A write and an IDLE→SCAN transition in the same cycle: the write is committed (state is still IDLE). A read of that address in SCAN sees the new data, so read-during-write returns new data.
- Simultaneous events:
  - mask_ready=1 together with vox_valid=1 in DONE: go to IDLE only; that voxel waits for the next cycle.
  - sticky=1 across frames: edge_mask keeps accumulating and vox_count continues from its held value.
- Reset mid-operation: returns to IDLE immediately. In-flight voxels and the partial mask are discarded; no mask_valid is produced.
- The edge_mask output register updates only while not in DONE. It reflects the accumulator and is architecturally meaningful only when mask_valid=1.

Decomposition:
- Package prm_edge_pkg: FSM state enum (IDLE, SCAN, DRAIN, DONE) and default CELL_W/NUM_EDGES constants.
- Sub-module prm_edge_lut: 1R1W synchronous RAM of 2^CELL_W x NUM_EDGES with 1-cycle read and write-first behaviour. This module is the technology-mapping point.
- Top-level contents: FSM, accumulator, counter, handshakes.

Test Plan:
- Load LUT[0x0005]=0x00000003 and LUT[0x7FFF]=0x80000000. Stream 0x0005, then 0x7FFF with last. Required: edge_mask=0x80000003, vox_count=2, mask_valid 2 cycles after the last accept.
- Frame of 1 voxel with LUT word 0, mask_ready held low 10 cycles. Required: mask_valid stays 1, edge_mask=0 stable; vox_ready=0 throughout DONE.
- Two frames:
  - Frame 1 (sticky=0): voxel with LUT word 0x1.
  - Frame 2 (sticky=0): voxel with LUT word 0x2 → mask=0x2, count=1.
  - Repeat with frame 2 at sticky=1 → mask=0x3, count=2.
- cfg_we pulsed during SCAN. Required: cfg_err=1 for one cycle; a later read of that address returns the old data.
- Assert rst_n low mid-SCAN after 3 beats. Required: all outputs zero and IDLE. The next frame's mask excludes the pre-reset voxels.
- With CNT_W=2, stream 5 voxels with random vox_valid gaps. Required: vox_count=3 (saturated); mask equals the OR of all 5 LUT words.
